sprite_table_reader: RTL
========================

Name: sprite_table_reader

Overview:
- Read-side initiator for the game-state data memory: on each frame_start pulse (vsync), it walks the fixed table of memory-mapped game-state words through a shared read port.
- Reads issue one per granted cycle; each returned word is captured into a staging bank.
- When the walk completes, all staging words are committed together into a shadow bank, so the VGA renderer always sees one coherent frame of positions, lives, score and laser state.
- Sits between the memory arbiter (shared with the CPU) and the renderer.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDRESS_WIDTH, 12, memory address width.
- NUM_SPRITES, 10, enemy sprite slots fetched.
- NUM_ENTRIES, 25, total fetch-list length (2*NUM_SPRITES + 5).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse that starts a fetch pass.
- mem_req  out  1  read request to the arbiter.
- mem_gnt  in  1  arbiter grant; the read is issued in any cycle where mem_req && mem_gnt.
- mem_addr  out  ADDRESS_WIDTH  read address; valid while mem_req=1.
- mem_rdata  in  DATA_WIDTH  memory read data; registered, valid the cycle after issue.
- sprite_x  out  NUM_SPRITES*DATA_WIDTH  packed X coordinates, slot k at bits [k*32 +: 32].
- sprite_y  out  NUM_SPRITES*DATA_WIDTH  packed Y coordinates.
- player_x, player_y  out  DATA_WIDTH  player position.
- laser, player_lives, player_score  out  DATA_WIDTH  status words.
- frame_ready  out  1  one-cycle pulse in the cycle after the shadow bank updates.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky flag: frame_start arrived while busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset, asynchronous, active-low, takes effect at any time including mid-pass:
  - state goes to IDLE; issue index and capture pipeline are cleared.
  - mem_req=0, frame_ready=0, busy=0, overrun=0.
  - All shadow and staging registers are 0.
  - mem_addr resets to 0.
- Fetch list, index i to address:
  - Sprite k (k = 1..NUM_SPRITES): X at 1000+10k, Y at 1001+10k, at list indices 2(k-1) and 2(k-1)+1.
  - Then, in order: player X 2000, player Y 2001, laser 1200, lives 1250, score 1300.
- State machine IDLE -> FETCH -> DRAIN -> COMMIT -> IDLE:
  - IDLE: mem_req=0. frame_start=1 moves to FETCH with idx=0.
  - FETCH: mem_req=1, mem_addr=ADDR[idx].
    - On each edge with mem_gnt=1, idx increments.
    - When idx=NUM_ENTRIES-1 is granted, move to DRAIN.
    - mem_gnt=0 stalls: idx, mem_addr and mem_req are held, with no timeout.
  - Capture pipeline: a 1-bit issued flag plus a registered tag (idx at issue).
    - On the edge after an issue, staging[tag] <= mem_rdata.
  - DRAIN: mem_req=0; waits one edge for the final capture, then moves to COMMIT.
  - COMMIT: all shadow outputs <= staging in a single edge, frame_ready=1 for the following cycle, move to IDLE.
- Latency with mem_gnt held at 1:
  - frame_start is sampled at edge E0; issues happen at E1..E25; the last capture is at E26.
  - Shadow outputs update at E27; frame_ready is high during the cycle after E27.
- Shadow outputs change only at COMMIT and never show a partial frame.
- frame_start while busy (including the COMMIT cycle): ignored, and overrun is set to 1.
- If overrun_clr and a new overrun happen in the same cycle, set wins.
- frame_start in the same cycle that COMMIT returns to IDLE counts as busy and is ignored.
- The block never writes memory; it does not drive the memory wEn.

Decomposition:
- Package sprite_table_pkg holds:
  - the state enum;
  - NUM_ENTRIES;
  - base address constants (SPRITE_BASE=1000, SPRITE_STRIDE=10, PLAYER_X_ADDR=2000, PLAYER_Y_ADDR=2001, LASER_ADDR=1200, LIVES_ADDR=1250, SCORE_ADDR=1300);
  - a function mapping index to address.
- One natural sub-module, sprite_fetch_addr_rom: a combinational index-to-address mapping, kept separate so that changes to the table layout stay local.
- The FSM, capture pipeline and shadow bank stay in the top module.

Test Plan:
- Memory model preloaded with sprite k X=100+k, Y=200+k, player 320/450, laser 1, lives 3, score 1234; gnt tied 1; one frame_start -> frame_ready at E27 after the sample edge; outputs match exactly; mem_addr sequence is 1010,1011,…,1101,2000,2001,1200,1250,1300.
- Same preload, gnt toggled 0/1 every cycle -> each address is issued exactly once and in order; final outputs are identical to the first scenario; frame_ready arrives later than E27.
- Change memory contents mid-pass (after idx 5 has been issued) -> shadow outputs keep the previous frame's values until COMMIT; no output changes before frame_ready.
- frame_start pulsed at idx 10 -> pass completes normally, overrun=1; overrun_clr pulse -> overrun=0; simultaneous clr and a new frame_start while busy -> overrun=1.
- Assert reset_n low at idx 12 -> state goes to IDLE immediately (asynchronously); all outputs are 0; mem_req=0. A following frame_start restarts from address 1010 and produces a full, correct frame.

Source files
------------

// File: rtl/sprite_table_pkg.sv
// Game-state fetch table shared by the frame reader: state encoding, table constants, index-to-address map.
// Latency: none, pure definitions and a combinational helper function.
// Backpressure: none; callers decide how and when the table is walked.
package sprite_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam int NUM_SPRITES_DFLT = 10;
    localparam int NUM_ENTRIES      = 2 * NUM_SPRITES_DFLT + 5;

    localparam logic [31:0] SPRITE_BASE   = 32'd1000;
    localparam logic [31:0] SPRITE_STRIDE = 32'd10;
    localparam logic [31:0] PLAYER_X_ADDR = 32'd2000;
    localparam logic [31:0] PLAYER_Y_ADDR = 32'd2001;
    localparam logic [31:0] LASER_ADDR    = 32'd1200;
    localparam logic [31:0] LIVES_ADDR    = 32'd1250;
    localparam logic [31:0] SCORE_ADDR    = 32'd1300;

    // Sprite k (1-based) occupies list slots 2(k-1) (X) and 2(k-1)+1 (Y);
    // the five player/status words follow the sprite block in a fixed order.
    function automatic logic [31:0] entry_addr(input logic [31:0] idx,
                                               input logic [31:0] num_sprites);
        logic [31:0] addr;
        logic [31:0] k;
        logic [31:0] tail;
        addr = '0;
        k    = '0;
        tail = '0;
        if (idx < 32'd2 * num_sprites) begin
            k    = (idx >> 1) + 32'd1;
            addr = SPRITE_BASE + SPRITE_STRIDE * k + {31'd0, idx[0]};
        end else begin
            tail = idx - 32'd2 * num_sprites;
            case (tail)
                32'd0:   addr = PLAYER_X_ADDR;
                32'd1:   addr = PLAYER_Y_ADDR;
                32'd2:   addr = LASER_ADDR;
                32'd3:   addr = LIVES_ADDR;
                32'd4:   addr = SCORE_ADDR;
                default: addr = '0;
            endcase
        end
        return addr;
    endfunction

endpackage

// File: rtl/sprite_fetch_addr_rom.sv
// Maps a fetch-list index to its game-state memory address; table layout lives only here and in the package.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller holds idx stable while the address must stay valid.
module sprite_fetch_addr_rom
    import sprite_table_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 12,
    parameter int NUM_SPRITES   = 10,
    parameter int IDX_W         = 5
) (
    input  logic [IDX_W-1:0]         idx,
    output logic [ADDRESS_WIDTH-1:0] addr
);

    // Table lookup, truncated to the memory's address width.
    always_comb begin
        addr = ADDRESS_WIDTH'(entry_addr(32'(idx), 32'(NUM_SPRITES)));
    end

endmodule

// File: rtl/sprite_table_reader.sv
// Per-frame walker of the game-state table: reads every entry into staging, then commits all to the shadow bank at once.
// Latency: frame_start sampled at E0, issues E1..E25, last capture E26, shadow update E27 (grant held high).
// Backpressure: mem_gnt low stalls the walk indefinitely with index/address/request held; no timeout.
module sprite_table_reader
    import sprite_table_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int NUM_SPRITES   = 10,
    parameter int NUM_ENTRIES   = 2 * NUM_SPRITES + 5
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              frame_start,
    output logic                              mem_req,
    input  logic                              mem_gnt,
    output logic [ADDRESS_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic [NUM_SPRITES*DATA_WIDTH-1:0] sprite_x,
    output logic [NUM_SPRITES*DATA_WIDTH-1:0] sprite_y,
    output logic [DATA_WIDTH-1:0]             player_x,
    output logic [DATA_WIDTH-1:0]             player_y,
    output logic [DATA_WIDTH-1:0]             laser,
    output logic [DATA_WIDTH-1:0]             player_lives,
    output logic [DATA_WIDTH-1:0]             player_score,
    output logic                              frame_ready,
    output logic                              busy,
    output logic                              overrun,
    input  logic                              overrun_clr
);

    localparam int               IDX_W     = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
    localparam int               PX_IDX    = 2 * NUM_SPRITES;
    localparam int               PY_IDX    = 2 * NUM_SPRITES + 1;
    localparam int               LASER_IDX = 2 * NUM_SPRITES + 2;
    localparam int               LIVES_IDX = 2 * NUM_SPRITES + 3;
    localparam int               SCORE_IDX = 2 * NUM_SPRITES + 4;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     mem_req_q, mem_req_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                     issued_q, issued_d;
    logic [IDX_W-1:0]         tag_q, tag_d;
    logic [DATA_WIDTH-1:0]    staging_q [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]    staging_d [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]    shadow_q  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]    shadow_d  [NUM_ENTRIES];
    logic                     frame_ready_q, frame_ready_d;
    logic                     overrun_q, overrun_d;

    logic [IDX_W-1:0]         rom_idx;
    logic [ADDRESS_WIDTH-1:0] rom_addr;

    // Next entry to present: 0 when a pass starts, otherwise the one after the current index.
    assign rom_idx = (state_q == ST_FETCH) ? idx_q + IDX_W'(1) : '0;

    sprite_fetch_addr_rom #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_SPRITES   (NUM_SPRITES),
        .IDX_W         (IDX_W)
    ) u_addr_rom (
        .idx  (rom_idx),
        .addr (rom_addr)
    );

    // Next-state: walk control, one-deep capture pipeline, bulk commit and sticky overrun.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        issued_d      = 1'b0;
        tag_d         = tag_q;
        staging_d     = staging_q;
        shadow_d      = shadow_q;
        frame_ready_d = 1'b0;
        overrun_d     = overrun_q;

        // Read data is registered in memory, so it lands one edge after its issue.
        if (issued_q) begin
            staging_d[tag_q] = mem_rdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_FETCH;
                    idx_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = rom_addr;
                end
            end
            ST_FETCH: begin
                if (mem_gnt) begin
                    issued_d = 1'b1;
                    tag_d    = idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_DRAIN;
                        mem_req_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        mem_addr_d = rom_addr;
                    end
                end
            end
            ST_DRAIN: begin
                // The final capture happens on this edge; commit on the next.
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                shadow_d      = staging_q;
                frame_ready_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new overrun takes priority over a same-cycle clear.
        if (frame_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // State and output registers; reset clears everything including both data banks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            issued_q      <= 1'b0;
            tag_q         <= '0;
            staging_q     <= '{default: '0};
            shadow_q      <= '{default: '0};
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            issued_q      <= issued_d;
            tag_q         <= tag_d;
            staging_q     <= staging_d;
            shadow_q      <= shadow_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
        end
    end

    // Sprite slot k carries sprite k+1, whose X/Y sit at list entries 2k and 2k+1.
    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_slot
        assign sprite_x[k*DATA_WIDTH +: DATA_WIDTH] = shadow_q[2*k];
        assign sprite_y[k*DATA_WIDTH +: DATA_WIDTH] = shadow_q[2*k+1];
    end

    assign player_x     = shadow_q[PX_IDX];
    assign player_y     = shadow_q[PY_IDX];
    assign laser        = shadow_q[LASER_IDX];
    assign player_lives = shadow_q[LIVES_IDX];
    assign player_score = shadow_q[SCORE_IDX];

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign frame_ready  = frame_ready_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
